// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the UART TX async FIFO: round-robin between the ALU
// word source and the register-file byte source, serialising ALU words LSB first.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int ALU_WIDTH = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ALU_WIDTH-1:0] alu_data,
    output logic                 alu_ready,
    input  logic                 rf_valid,
    input  logic [WIDTH-1:0]     rf_data,
    output logic                 rf_ready,
    input  logic                 fifo_full,
    output logic                 fifo_winc,
    output logic [WIDTH-1:0]     fifo_wdata,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 last_rf;
    logic                 single;
    logic [ALU_WIDTH-1:0] buffer;
    logic                 grant_alu;
    logic                 grant_rf;

    // On contention the requester that did not win last time is served.
    always_comb begin
        grant_alu = (state == IDLE) && alu_valid && (!rf_valid || last_rf);
        grant_rf  = (state == IDLE) && rf_valid && (!alu_valid || !last_rf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_alu || grant_rf) next_state = WR_LO;
            WR_LO:   if (!fifo_full) next_state = single ? IDLE : WR_HI;
            WR_HI:   if (!fifo_full) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer    <= '0;
            last_rf   <= 1'b1;
            single    <= 1'b0;
            alu_ready <= 1'b0;
            rf_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            alu_ready <= grant_alu;
            rf_ready  <= grant_rf;
            busy      <= (next_state != IDLE);
            if (grant_alu) begin
                buffer  <= alu_data;
                last_rf <= 1'b0;
                single  <= 1'b0;
            end else if (grant_rf) begin
                buffer  <= {{(ALU_WIDTH - WIDTH){1'b0}}, rf_data};
                last_rf <= 1'b1;
                single  <= 1'b1;
            end
        end
    end

    always_comb begin
        fifo_winc  = (state != IDLE) && !fifo_full;
        fifo_wdata = '0;
        case (state)
            WR_LO:   fifo_wdata = buffer[0 +: WIDTH];
            WR_HI:   fifo_wdata = buffer[WIDTH +: WIDTH];
            default: fifo_wdata = '0;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected FIFO bytes are queued as each
// request is presented and popped as the arbiter writes them.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        rf_valid;
    logic [7:0]  rf_data;
    logic        rf_ready;
    logic        fifo_full;
    logic        fifo_winc;
    logic [7:0]  fifo_wdata;
    logic        busy;

    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          alu_cnt  = 0;
    int          rf_cnt   = 0;
    int          n_alu_rdy = 0;
    int          n_rf_rdy  = 0;
    int          n_busy    = 0;
    int          n_winc    = 0;

    fifo_wr_arbiter #(.WIDTH(8), .ALU_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .rf_valid  (rf_valid),
        .rf_data   (rf_data),
        .rf_ready  (rf_ready),
        .fifo_full (fifo_full),
        .fifo_winc (fifo_winc),
        .fifo_wdata(fifo_wdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sampled on the falling edge: a write is committed at the next rising edge.
    always @(negedge clk) begin
        if (alu_ready) n_alu_rdy++;
        if (rf_ready)  n_rf_rdy++;
        if (busy)      n_busy++;
        if (fifo_winc) begin
            n_winc++;
            check("write_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) check("wdata", {8'h00, fifo_wdata}, {8'h00, exp_q.pop_front()});
        end
    end

    task automatic clear_counts();
        n_alu_rdy = 0;
        n_rf_rdy  = 0;
        n_busy    = 0;
        n_winc    = 0;
    endtask

    // Sources drop valid once their remaining item count reaches zero.
    task automatic tick();
        @(posedge clk);
        #1;
        if (alu_ready && alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) alu_valid = 1'b0;
        end
        if (rf_ready && rf_cnt > 0) begin
            rf_cnt--;
            if (rf_cnt == 0) rf_valid = 1'b0;
        end
    endtask

    task automatic run_until_done(input string tag, input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !busy && !alu_valid && !rf_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(tag, {15'd0, done}, 16'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_alu_ready"}, {15'd0, alu_ready}, 16'd0);
        check({tag, "_rf_ready"},  {15'd0, rf_ready},  16'd0);
        check({tag, "_winc"},      {15'd0, fifo_winc}, 16'd0);
        check({tag, "_wdata"},     {8'h00, fifo_wdata}, 16'h0000);
        check({tag, "_busy"},      {15'd0, busy},      16'd0);
    endtask

    initial begin
        rst       = 1'b0;
        fifo_full = 1'b0;
        alu_valid = 1'b1;
        alu_data  = 16'h1122;
        rf_valid  = 1'b1;
        rf_data   = 8'h77;
        alu_cnt   = 2;
        rf_cnt    = 2;

        // Reset held with both requesters active, then strict alternation, ALU first.
        repeat (3) tick();
        check_quiet("reset");
        exp_q = '{8'h22, 8'h11, 8'h77, 8'h22, 8'h11, 8'h77};
        clear_counts();
        rst = 1'b1;
        run_until_done("alternate_done", 60);
        check("alternate_alu_acks", 16'(n_alu_rdy), 16'd2);
        check("alternate_rf_acks",  16'(n_rf_rdy),  16'd2);
        check("alternate_writes",   16'(n_winc),    16'd6);

        // Single register-file byte.
        tick();
        clear_counts();
        rf_data  = 8'h3C;
        rf_valid = 1'b1;
        rf_cnt   = 1;
        exp_q.push_back(8'h3C);
        run_until_done("rf_done", 20);
        repeat (2) tick();
        check("rf_ready_cycles", 16'(n_rf_rdy),  16'd1);
        check("rf_alu_ready",    16'(n_alu_rdy), 16'd0);
        check("rf_winc_cycles",  16'(n_winc),    16'd1);
        check("rf_busy_cycles",  16'(n_busy),    16'd1);

        // Single ALU word: low byte then high byte on consecutive cycles.
        clear_counts();
        alu_data  = 16'hA5C3;
        alu_valid = 1'b1;
        alu_cnt   = 1;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hA5);
        run_until_done("alu_done", 20);
        repeat (2) tick();
        check("alu_ready_cycles", 16'(n_alu_rdy), 16'd1);
        check("alu_rf_ready",     16'(n_rf_rdy),  16'd0);
        check("alu_winc_cycles",  16'(n_winc),    16'd2);
        check("alu_busy_cycles",  16'(n_busy),    16'd2);

        // FIFO goes full after the low byte and stays full for four cycles.
        clear_counts();
        alu_data  = 16'hBEEF;
        alu_valid = 1'b1;
        alu_cnt   = 1;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        tick();
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_winc",  {15'd0, fifo_winc}, 16'd0);
            check("stall_wdata", {8'h00, fifo_wdata}, 16'h00BE);
            check("stall_busy",  {15'd0, busy},      16'd1);
            tick();
        end
        fifo_full = 1'b0;
        run_until_done("stall_done", 20);
        repeat (2) tick();
        check("stall_winc_cycles", 16'(n_winc), 16'd2);

        // Reset during the high-byte phase drops the rest of the word.
        clear_counts();
        alu_data  = 16'h1234;
        alu_valid = 1'b1;
        alu_cnt   = 1;
        exp_q.push_back(8'h34);
        tick();
        tick();
        check("abort_pre_busy", {15'd0, busy}, 16'd1);
        rst = 1'b0;
        #1;
        check_quiet("abort");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort_idle_busy", {15'd0, busy}, 16'd0);
        check("abort_queue", 16'(exp_q.size()), 16'd0);
        check("abort_alu_acks", 16'(n_alu_rdy), 16'd1);

        clear_counts();
        rf_data  = 8'h5A;
        rf_valid = 1'b1;
        rf_cnt   = 1;
        exp_q.push_back(8'h5A);
        run_until_done("post_abort_done", 20);
        repeat (2) tick();
        check("post_abort_writes", 16'(n_winc),   16'd1);
        check("post_abort_acks",   16'(n_rf_rdy), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
